ysyx_23060332_regfile_wb: RTL and testbench
===========================================

Name: ysyx_23060332_regfile_wb

Overview:
- Write-back end of the execute→register-file interface: the ALU emits (wen, wdata) from an instruction and consumes rs1 read data; this block accepts those writes and supplies operand reads.
- Holds the 32-entry GPR array behind a one-entry write-back staging register with valid/ready handshake.
- Provides two combinational read ports with bypass from the staged write, plus a per-register busy scoreboard.
- Sits between the ALU/EXU write-back output and the IDU/EXU operand fetch.

Parameters:
- XLEN, 32, register data width.
- NR_REGS, 32, number of architectural registers; AW = $clog2(NR_REGS) = 5.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- wb_valid_i  in  1  write-back request valid.
- wb_ready_o  out  1  block can accept a request this cycle.
- wb_wen_i  in  1  request actually writes a register (ALU wen).
- wb_waddr_i  in  AW  destination register (inst[11:7]).
- wb_wdata_i  in  XLEN  result (ALU wdata).
- wb_hold_i  in  1  freezes commit of the staged write (debug halt).
- raddr1_i  in  AW  read port 1 address.
- rdata1_o  out  XLEN  read port 1 data.
- raddr2_i  in  AW  read port 2 address.
- rdata2_o  out  XLEN  read port 2 data.
- busy_o  out  NR_REGS  bit i = register i has a staged, uncommitted write.

Behaviour:
- Staging states: EMPTY, FULL (1-bit stage_valid). Handshake completes when wb_valid_i && wb_ready_o at a rising edge.
- wb_ready_o = !stage_valid || !wb_hold_i (combinational). Commit is stage_valid && !wb_hold_i.
- Accepted request with wb_wen_i=1 and wb_waddr_i!=0 loads the stage (addr, data), giving FULL next cycle. Any other accepted request (wen=0 or x0) is consumed and discarded; stage is unchanged.
- Commit writes the stage into the array on that edge; state goes to EMPTY unless a new staging request is accepted the same edge, in which case it stays FULL with the new entry.
- Latency: accept at edge N → visible via bypass from N+ → in array at edge N+1 (if no hold).
- Hold while FULL: the stage is frozen, ready=0, and no acceptance occurs.
- Reads are combinational. If raddr==0, data is 0. Else if stage_valid and stage_addr==raddr, data is stage_data. Else data is the array value. Both ports are independent and may use the same address.
- busy_o: one-hot of stage_addr when FULL, else 0. Bit 0 is never set.
- Back-to-back writes to the same register: the newer value wins in stage and array; no lost ordering.
- Reset (asynchronous, any time, including mid-hold): array all zero, stage EMPTY, and the staged write is dropped. Resulting outputs are wb_ready_o=1, busy_o=0, rdata*=0.
- Array x0 is never written; it is not required to be stored.

Optional Feature:
- Macro YSYX_23060332_COMMIT_PORT_EN.
- Defined: adds outputs commit_valid_o (1), commit_addr_o (AW), commit_data_o (XLEN). They are registered and pulse for one cycle on the cycle after each commit, carrying the committed addr/data, for difftest/trace. All reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ysyx_23060332_pkg holds XLEN, NR_REGS, AW, the REG_ZERO constant, and the stage-state encoding (EMPTY=1'b0, FULL=1'b1).
- One natural sub-module, ysyx_23060332_regfile_array: the flop array with async reset, one write port, two raw read ports. The top holds the stage, handshake, bypass and scoreboard.

Test Plan:
- Reset then read x5 and x0 → both 0; wb_ready_o=1; busy_o=0.
- Accept (wen=1, addr=3, data=0x0000_0007), then read x3 the next cycle → 0x7 via bypass, busy_o=0x8. The cycle after, x3 reads 0x7 from the array and busy_o=0.
- Accept (addr=0, data=0xFFFF_FFFF) and (wen=0, addr=4, data=0x55) → x0=0, x4 unchanged; busy_o stays 0.
- Stage addr=7/0x11, assert wb_hold_i for 3 cycles with valid request addr=8/0x22 waiting → wb_ready_o=0 throughout, x7 reads 0x11 via bypass. Release hold → x7 commits, x8 is accepted the same edge.
- Consecutive writes to x9: 0x1 then 0x2 on adjacent cycles → rdata reads 0x1 then 0x2, and the final array x9 = 0x2.
- Assert rst_n=0 mid-cycle while FULL (x10/0xAB) → the stage drops immediately, and x10 reads 0 after reset. With YSYX_23060332_COMMIT_PORT_EN defined, no commit pulse occurs for x10.

Source files
------------

// File: rtl/ysyx_23060332_regfile_wb_pkg.sv
// Shared definitions for the register-file write-back slice.
package ysyx_23060332_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NR_REGS = 32;
  localparam int unsigned AW      = $clog2(NR_REGS);

  localparam logic [AW-1:0] REG_ZERO = '0;

  // Write-back staging register occupancy
  typedef enum logic {
    STAGE_EMPTY = 1'b0,
    STAGE_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/ysyx_23060332_regfile_wb_if.sv
// Write-back request channel: ALU/EXU (master) -> register file (slave).
interface ysyx_23060332_regfile_wb_if
  import ysyx_23060332_pkg::*;
();

  logic            valid;
  logic            ready;
  logic            wen;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic            hold;

  modport master (
    output valid, wen, waddr, wdata, hold,
    input  ready
  );

  modport slave (
    input  valid, wen, waddr, wdata, hold,
    output ready
  );

endinterface

// File: rtl/ysyx_23060332_regfile_array.sv
// Flop-based GPR array: one write port, two raw combinational read ports.
// x0 reads as zero and is never written.
module ysyx_23060332_regfile_array
  import ysyx_23060332_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NR_REGS];

  // Register storage with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NR_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != REG_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  // Raw reads, x0 forced to zero
  always_comb begin
    rdata1 = (raddr1 == REG_ZERO) ? '0 : regs[raddr1];
    rdata2 = (raddr2 == REG_ZERO) ? '0 : regs[raddr2];
  end

endmodule

// File: rtl/ysyx_23060332_regfile_wb.sv
// Register-file write-back end: one-entry staging register with valid/ready
// handshake, bypassed read ports and a per-register busy scoreboard.
// Optional macro YSYX_23060332_COMMIT_PORT_EN adds a registered commit trace port.
module ysyx_23060332_regfile_wb
  import ysyx_23060332_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  ysyx_23060332_regfile_wb_if.slave wb,
  input  logic [AW-1:0]        raddr1_i,
  output logic [XLEN-1:0]      rdata1_o,
  input  logic [AW-1:0]        raddr2_i,
  output logic [XLEN-1:0]      rdata2_o,
  output logic [NR_REGS-1:0]   busy_o
`ifdef YSYX_23060332_COMMIT_PORT_EN
  ,
  output logic                 commit_valid_o,
  output logic [AW-1:0]        commit_addr_o,
  output logic [XLEN-1:0]      commit_data_o
`endif
);

  stage_state_e    state, state_nxt;
  logic [AW-1:0]   stage_addr;
  logic [XLEN-1:0] stage_data;
  logic            stage_valid;
  logic            accept;
  logic            load;
  logic            commit;
  logic [XLEN-1:0] arr_rdata1;
  logic [XLEN-1:0] arr_rdata2;

  assign stage_valid = (state == STAGE_FULL);

  // Handshake and stage control decode
  always_comb begin
    wb.ready = !stage_valid || !wb.hold;
    accept   = wb.valid && wb.ready;
    load     = accept && wb.wen && (wb.waddr != REG_ZERO);
    commit   = stage_valid && !wb.hold;
  end

  // Next stage occupancy: a same-edge load keeps the stage full across a commit
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = STAGE_FULL;
    end else if (commit) begin
      state_nxt = STAGE_EMPTY;
    end
  end

  // Stage occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STAGE_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage payload, captured on every staging load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_addr <= '0;
      stage_data <= '0;
    end else if (load) begin
      stage_addr <= wb.waddr;
      stage_data <= wb.wdata;
    end
  end

  ysyx_23060332_regfile_array u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (commit),
    .waddr  (stage_addr),
    .wdata  (stage_data),
    .raddr1 (raddr1_i),
    .rdata1 (arr_rdata1),
    .raddr2 (raddr2_i),
    .rdata2 (arr_rdata2)
  );

  // Operand reads with bypass from the uncommitted stage
  always_comb begin
    rdata1_o = arr_rdata1;
    rdata2_o = arr_rdata2;
    if (raddr1_i == REG_ZERO) begin
      rdata1_o = '0;
    end else if (stage_valid && (stage_addr == raddr1_i)) begin
      rdata1_o = stage_data;
    end
    if (raddr2_i == REG_ZERO) begin
      rdata2_o = '0;
    end else if (stage_valid && (stage_addr == raddr2_i)) begin
      rdata2_o = stage_data;
    end
  end

  // Busy scoreboard: one-hot of the staged destination
  always_comb begin
    busy_o = '0;
    if (stage_valid) begin
      busy_o = NR_REGS'(1) << stage_addr;
    end
  end

`ifdef YSYX_23060332_COMMIT_PORT_EN
  // Commit trace, one-cycle pulse after each array write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid_o <= 1'b0;
      commit_addr_o  <= '0;
      commit_data_o  <= '0;
    end else begin
      commit_valid_o <= commit;
      commit_addr_o  <= commit ? stage_addr : '0;
      commit_data_o  <= commit ? stage_data : '0;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060332_regfile_wb.sv
// Directed bench for ysyx_23060332_regfile_wb.
module tb_ysyx_23060332_regfile_wb;
  import ysyx_23060332_pkg::*;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   raddr1;
  logic [XLEN-1:0] rdata1;
  logic [AW-1:0]   raddr2;
  logic [XLEN-1:0] rdata2;
  logic [NR_REGS-1:0] busy;
`ifdef YSYX_23060332_COMMIT_PORT_EN
  logic            commit_valid;
  logic [AW-1:0]   commit_addr;
  logic [XLEN-1:0] commit_data;
`endif

  int unsigned n_checks;
  int unsigned n_pass;

  ysyx_23060332_regfile_wb_if wb_if ();

  ysyx_23060332_regfile_wb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb       (wb_if.slave),
    .raddr1_i (raddr1),
    .rdata1_o (rdata1),
    .raddr2_i (raddr2),
    .rdata2_o (rdata2),
    .busy_o   (busy)
`ifdef YSYX_23060332_COMMIT_PORT_EN
    ,
    .commit_valid_o (commit_valid),
    .commit_addr_o  (commit_addr),
    .commit_data_o  (commit_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; sampling happens 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    raddr1 = a1;
    raddr2 = a2;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    wb_if.valid = 1'b0;
    wb_if.wen   = 1'b0;
    wb_if.waddr = '0;
    wb_if.wdata = '0;
    wb_if.hold  = 1'b0;
    raddr1 = '0;
    raddr2 = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Reset state
    rd(5'd5, 5'd0);
    chk("rst_x5", rdata1, 32'h0);
    chk("rst_x0", rdata2, 32'h0);
    chk("rst_ready", {31'b0, wb_if.ready}, 32'h1);
    chk("rst_busy", busy, 32'h0);

    // Single write to x3: bypass then array
    wb_if.valid = 1'b1; wb_if.wen = 1'b1; wb_if.waddr = 5'd3; wb_if.wdata = 32'h7;
    step();
    wb_if.valid = 1'b0;
    rd(5'd3, 5'd3);
    chk("x3_bypass", rdata1, 32'h7);
    chk("x3_bypass_p2", rdata2, 32'h7);
    chk("x3_busy", busy, 32'h0000_0008);
    step();
    chk("x3_array", rdata1, 32'h7);
    chk("x3_busy_clr", busy, 32'h0);
`ifdef YSYX_23060332_COMMIT_PORT_EN
    chk("x3_cvalid", {31'b0, commit_valid}, 32'h1);
    chk("x3_caddr", {27'b0, commit_addr}, 32'd3);
    chk("x3_cdata", commit_data, 32'h7);
    step();
    chk("x3_cvalid_end", {31'b0, commit_valid}, 32'h0);
`endif

    // Writes that must be discarded: x0 target, wen=0
    wb_if.valid = 1'b1; wb_if.wen = 1'b1; wb_if.waddr = 5'd0; wb_if.wdata = 32'hFFFF_FFFF;
    step();
    chk("x0_busy", busy, 32'h0);
    chk("x0_ready", {31'b0, wb_if.ready}, 32'h1);
    wb_if.wen = 1'b0; wb_if.waddr = 5'd4; wb_if.wdata = 32'h55;
    step();
    wb_if.valid = 1'b0;
    rd(5'd0, 5'd4);
    chk("x0_zero", rdata1, 32'h0);
    chk("x4_unchanged", rdata2, 32'h0);
    chk("nowen_busy", busy, 32'h0);
    step();
    chk("x4_unchanged_late", rdata2, 32'h0);

    // Hold while full
    wb_if.valid = 1'b1; wb_if.wen = 1'b1; wb_if.waddr = 5'd7; wb_if.wdata = 32'h11;
    step();
    wb_if.hold = 1'b1; wb_if.waddr = 5'd8; wb_if.wdata = 32'h22;
    rd(5'd7, 5'd8);
    chk("hold_ready0", {31'b0, wb_if.ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_ready", {31'b0, wb_if.ready}, 32'h0);
      chk("hold_x7", rdata1, 32'h11);
      chk("hold_x8", rdata2, 32'h0);
      chk("hold_busy", busy, 32'h0000_0080);
    end
    wb_if.hold = 1'b0;
    #1;
    chk("release_ready", {31'b0, wb_if.ready}, 32'h1);
    step();
    wb_if.valid = 1'b0;
    chk("release_busy", busy, 32'h0000_0100);
    chk("release_x7", rdata1, 32'h11);
    chk("release_x8", rdata2, 32'h22);
    step();
    chk("release_busy_clr", busy, 32'h0);
    chk("release_x8_arr", rdata2, 32'h22);

    // Back-to-back writes to x9
    wb_if.valid = 1'b1; wb_if.wen = 1'b1; wb_if.waddr = 5'd9; wb_if.wdata = 32'h1;
    rd(5'd9, 5'd3);
    step();
    chk("x9_first", rdata1, 32'h1);
    wb_if.wdata = 32'h2;
    step();
    wb_if.valid = 1'b0;
    chk("x9_second", rdata1, 32'h2);
    chk("x9_busy", busy, 32'h0000_0200);
    step();
    chk("x9_array", rdata1, 32'h2);
    chk("x9_busy_clr", busy, 32'h0);
    chk("x3_still", rdata2, 32'h7);

    // Asynchronous reset while full
    wb_if.valid = 1'b1; wb_if.wen = 1'b1; wb_if.waddr = 5'd10; wb_if.wdata = 32'hAB;
    step();
    wb_if.valid = 1'b0;
    rd(5'd10, 5'd3);
    chk("x10_bypass", rdata1, 32'hAB);
    chk("x10_busy", busy, 32'h0000_0400);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 32'h0);
    chk("arst_ready", {31'b0, wb_if.ready}, 32'h1);
    chk("arst_x10", rdata1, 32'h0);
    chk("arst_x3", rdata2, 32'h0);
    step();
    rst_n = 1'b1;
`ifdef YSYX_23060332_COMMIT_PORT_EN
    chk("arst_cvalid", {31'b0, commit_valid}, 32'h0);
`endif
    step();
    chk("post_rst_x10", rdata1, 32'h0);
    chk("post_rst_busy", busy, 32'h0);
`ifdef YSYX_23060332_COMMIT_PORT_EN
    chk("post_rst_cvalid", {31'b0, commit_valid}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
